window_shift_scheduler: RTL and testbench
=========================================

Name: window_shift_scheduler

Overview:
- Sequences the sliding-window shift register of the stream monitor (window of DEPTH signed samples).
- Buffers incoming stream events in a small FIFO and issues one shift pulse per event.
- Starts one evaluation of the monitor per event, plus periodic evaluations from an internal timer.
- Sits between the event input interface and the window/evaluation datapath; serialises shift and evaluate so they never overlap.

Parameters:
- DATA_W, 64: event sample width, signed.
- DEPTH, 5: window length; saturation limit of fill.
- FIFO_DEPTH, 4: event FIFO entries; power of two, >= 2.
- PERIOD, 10: enabled cycles between periodic ticks; >= 2.
- TIMEOUT, 64: eval_done timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; low freezes all state.
- ev_valid  in  1  event offered.
- ev_ready  out  1  FIFO can accept.
- ev_data  in  DATA_W  signed event sample.
- win_shift  out  1  one-cycle shift-enable pulse to the window.
- win_data  out  DATA_W  sample to shift in; valid when win_shift=1.
- eval_start  out  1  one-cycle evaluation request.
- eval_kind  out  1  0 = event-triggered, 1 = periodic; valid with eval_start.
- eval_done  in  1  evaluation complete.
- fill  out  $clog2(DEPTH+1)  valid entries in window, saturating at DEPTH.
- busy  out  1  FSM not in IDLE.
- tick_miss  out  1  sticky; a periodic tick arrived while one was already pending.
- eval_timeout  out  1  sticky; see Optional Feature.

Behaviour:
- Reset values (asserted asynchronously):
  - FSM = IDLE; FIFO empty; fill = 0; timer = 0; tick_pending = 0.
  - win_shift = 0, win_data = 0, eval_start = 0, eval_kind = 0, busy = 0, tick_miss = 0, eval_timeout = 0.
  - ev_ready = 0 while rst is high.
- Handshake:
  - ev_ready = en && !fifo_full.
  - Push when ev_valid && ev_ready at a rising edge.
  - When the FIFO is full, ready stays low even if a pop occurs in the same cycle.
  - ev_data must be held stable while ev_valid is high and ready is low.
- Timer:
  - Counts only when en=1; wraps at PERIOD-1, setting tick_pending.
  - If tick_pending is already 1 at wrap: set tick_miss; tick_pending stays 1.
- FSM (advances only when en=1; registered outputs):
  - IDLE: if tick_pending, go to EVAL with kind=1 and clear tick_pending. Else if FIFO not empty, go to SHIFT. Periodic has priority.
  - SHIFT: win_shift=1, win_data=FIFO head, pop; fill = min(fill+1, DEPTH); next state EVAL with kind=0.
  - EVAL: eval_start=1 for exactly one cycle; next state WAIT.
  - WAIT: hold until eval_done=1, then IDLE. eval_done is ignored in all other states.
- Latency from an empty/IDLE start, with the handshake in cycle 0:
  - win_shift high in cycle 2.
  - eval_start (kind 0) high in cycle 3.
  - Earliest next SHIFT is 2 cycles after the eval_done sample.
- win_data holds its last value outside SHIFT.
- en=0:
  - All registers hold, ev_ready=0, pulse outputs forced to 0.
  - A pulse interrupted by en falling re-issues when en returns, since the state is held.
- Reset mid-evaluation: everything returns to reset values; buffered events are discarded; fill = 0.

Optional Feature:
- Macro: SCHED_EVAL_TIMEOUT_EN.
- Defined:
  - WAIT counts enabled cycles.
  - If TIMEOUT cycles elapse without eval_done: go to IDLE and set eval_timeout (sticky until rst).
  - An eval_done arriving in the same cycle as the timeout counts as done; no flag is set.
- Undefined: no counter is built; WAIT waits indefinitely; eval_timeout is tied to 0.

Test Plan:
- Single event data=1 after reset: win_shift high in cycle 2 with win_data=1; eval_start in cycle 3 with eval_kind=0; eval_done returned in cycle 5 -> busy=0 in cycle 6; fill=1.
- Back-to-back events 1..6, ev_valid held high, eval_done held high:
  - six shifts with win_data 1,2,3,4,5,6 in order;
  - fill saturates at 5;
  - ev_ready drops when 4 entries are buffered.
- Withhold eval_done for 40 cycles, PERIOD=10, event and tick both pending at return to IDLE: periodic eval (kind=1) is issued before the queued shift; tick_miss=1.
- en low for 3 cycles during SHIFT: win_shift=0 while low, re-asserted for one cycle after en rises; timer frozen.
- Async rst pulse mid-WAIT with 3 events queued: outputs return to reset values immediately; no further shifts after release; fill=0.
- SCHED_EVAL_TIMEOUT_EN defined, TIMEOUT=64, eval_done never asserted: FSM returns to IDLE after 64 cycles; eval_timeout=1; the next queued event proceeds normally.

Source files
------------

// File: rtl/window_shift_scheduler.sv
// window_shift_scheduler: buffers stream events and serialises window shifts with event/periodic evaluations.
// Optional eval_done timeout in WAIT is built when SCHED_EVAL_TIMEOUT_EN is defined.
module window_shift_scheduler #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD     = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic signed [DATA_W-1:0]         ev_data,
  output logic                             win_shift,
  output logic signed [DATA_W-1:0]         win_data,
  output logic                             eval_start,
  output logic                             eval_kind,
  input  logic                             eval_done,
  output logic [$clog2(DEPTH+1)-1:0]       fill,
  output logic                             busy,
  output logic                             tick_miss,
  output logic                             eval_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int TW = $clog2(PERIOD);
  typedef enum logic [1:0] {IDLE, SHIFT, EVAL, WAIT} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic tick_pending, full, empty, push, wrap, take_tick;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign ev_ready = en && !rst && !full;
  assign push = ev_valid && ev_ready;
  assign wrap = timer == TW'(PERIOD-1);
  assign take_tick = state == IDLE && tick_pending;
  // Pulses come straight from the held state, so a pulse masked by en re-issues when en returns.
  assign win_shift = en && state == SHIFT;
  assign eval_start = en && state == EVAL;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_data;
  end
`ifdef SCHED_EVAL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] wcnt;
`else
  assign eval_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      timer <= '0;
      tick_pending <= 1'b0;
      tick_miss <= 1'b0;
      win_data <= '0;
      eval_kind <= 1'b0;
      fill <= '0;
`ifdef SCHED_EVAL_TIMEOUT_EN
      wcnt <= '0;
      eval_timeout <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (en) begin
        timer <= wrap ? '0 : timer + 1'b1;
        // A tick being consumed this cycle is not lost, so only an unconsumed one counts as missed.
        tick_pending <= wrap || (tick_pending && !take_tick);
        if (wrap && tick_pending && !take_tick) tick_miss <= 1'b1;
        case (state)
          IDLE: begin
            if (tick_pending) begin
              state <= EVAL;
              eval_kind <= 1'b1;
            end else if (!empty) begin
              state <= SHIFT;
              win_data <= mem[rd_ptr[AW-1:0]];
            end
          end
          SHIFT: begin
            rd_ptr <= rd_ptr + 1'b1;
            fill <= fill == FW'(DEPTH) ? fill : fill + 1'b1;
            eval_kind <= 1'b0;
            state <= EVAL;
          end
          EVAL: begin
            state <= WAIT;
`ifdef SCHED_EVAL_TIMEOUT_EN
            wcnt <= '0;
`endif
          end
          WAIT: begin
`ifdef SCHED_EVAL_TIMEOUT_EN
            if (eval_done) state <= IDLE;
            else if (wcnt == CW'(TIMEOUT-1)) begin
              state <= IDLE;
              eval_timeout <= 1'b1;
            end else wcnt <= wcnt + 1'b1;
`else
            if (eval_done) state <= IDLE;
`endif
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_window_shift_scheduler.sv
// tb_window_shift_scheduler: directed and randomized stimulus with a queue scoreboard and ordering-rule monitor.
module tb_window_shift_scheduler;
  localparam int DATA_W = 64, DEPTH = 5, FIFO_DEPTH = 4, PERIOD = 10, TIMEOUT = 64;
  logic clk = 0, rst = 1, en = 1, ev_valid = 0, eval_done = 0;
  logic signed [DATA_W-1:0] ev_data = '0;
  logic ev_ready, win_shift, eval_start, eval_kind, busy, tick_miss, eval_timeout;
  logic signed [DATA_W-1:0] win_data;
  logic [$clog2(DEPTH+1)-1:0] fill;
  int n_checks = 0, n_errors = 0;

  window_shift_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
                           .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .win_shift(win_shift), .win_data(win_data), .eval_start(eval_start), .eval_kind(eval_kind),
    .eval_done(eval_done), .fill(fill), .busy(busy), .tick_miss(tick_miss), .eval_timeout(eval_timeout));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted samples awaiting their shift, shift count, owed event evaluation.
  logic signed [DATA_W-1:0] exp_q[$];
  int shifts = 0, periodic = 0, en_cycles = 0;
  bit owed = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", ev_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fill", fill, 0);
      exp_q.delete();
      shifts = 0; periodic = 0; en_cycles = 0; owed = 0;
    end else begin
      chk("ready", ev_ready, en && exp_q.size() < FIFO_DEPTH);
      chk("fill", fill, shifts < DEPTH ? shifts : DEPTH);
      if (!en) chk("gated_pulses", {win_shift, eval_start}, 0);
      if (win_shift) begin
        chk("shift_has_data", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("win_data", win_data, exp_q.pop_front());
        chk("shift_eval_order", owed, 0);
        owed = 1;
        shifts++;
      end
      if (eval_start) begin
        chk("eval_kind", eval_kind, owed ? 0 : 1);
        if (!owed) begin
          periodic++;
          chk("periodic_bound", periodic <= en_cycles / PERIOD, 1);
        end
        owed = 0;
      end
      if (ev_valid && ev_ready) exp_q.push_back(ev_data);
      if (en) en_cycles++;
    end
  end

  int stalls = 0;
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic signed [DATA_W-1:0] v);
    int t = 0;
    bit ok;
    ev_valid = 1; ev_data = v;
    do begin
      @(negedge clk); ok = ev_ready; step(); t++;
      if (!ok) stalls++;
    end while (!ok && t < 200);
    chk("send_accept", ok, 1);
    ev_valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 400) begin step(); t++; end
    chk("drain", busy || exp_q.size() != 0, 0);
  endtask

  initial begin
    int t;
    bit acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_shift", win_shift, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_eval_start", eval_start, 0);
    chk("rst_eval_kind", eval_kind, 0);
    chk("rst_tick_miss", tick_miss, 0);
    chk("rst_eval_timeout", eval_timeout, 0);
    rst = 0;
    // single event latency
    ev_valid = 1; ev_data = 1;
    step(); ev_valid = 0;
    chk("c1_win_shift", win_shift, 0);
    step();
    chk("c2_win_shift", win_shift, 1);
    chk("c2_win_data", win_data, 1);
    step();
    chk("c3_eval_start", eval_start, 1);
    chk("c3_eval_kind", eval_kind, 0);
    step();
    chk("c4_busy", busy, 1);
    step(); eval_done = 1;
    step(); eval_done = 0;
    chk("c6_busy", busy, 0);
    chk("c6_fill", fill, 1);
    // back-to-back events
    eval_done = 1;
    for (int v = 1; v <= 6; v++) send(v);
    wait_idle();
    chk("b2b_ready_dropped", stalls > 0, 1);
    chk("b2b_shift_count", shifts, 7);
    chk("b2b_fill_sat", fill, DEPTH);
    // stuck evaluation with a tick and an event pending
    chk("pre_tick_miss", tick_miss, 0);
    eval_done = 0;
    send(100); send(101);
    repeat (40) step();
    chk("stuck_busy", busy, 1);
    chk("stuck_tick_miss", tick_miss, 1);
    eval_done = 1; step(); eval_done = 0;
    t = 0;
    while (!eval_start && !win_shift && t < 20) begin step(); t++; end
    chk("prio_eval_first", eval_start, 1);
    chk("prio_kind", eval_kind, 1);
    chk("prio_no_shift", win_shift, 0);
    eval_done = 1;
    wait_idle();
    // enable dropped during SHIFT
    send(55);
    t = 0;
    while (!win_shift && t < 50) begin step(); t++; end
    chk("en_shift_seen", win_shift, 1);
    en = 0; #1;
    chk("en_low_shift", win_shift, 0);
    chk("en_low_ready", ev_ready, 0);
    repeat (3) begin
      step();
      chk("en_hold_shift", win_shift, 0);
      chk("en_hold_busy", busy, 1);
    end
    en = 1; #1;
    chk("en_reissue_shift", win_shift, 1);
    chk("en_reissue_data", win_data, 55);
    step();
    chk("en_one_pulse", win_shift, 0);
    chk("en_eval_start", eval_start, 1);
    wait_idle();
    // randomized traffic
    acc = 0;
    for (int i = 0; i < 500; i++) begin
      if (!ev_valid || acc) begin
        ev_valid = $urandom_range(0, 2) != 0;
        ev_data = {$urandom, $urandom};
      end
      en = $urandom_range(0, 9) != 0;
      eval_done = $urandom_range(0, 2) == 0;
      @(negedge clk); acc = ev_valid && ev_ready;
      step();
    end
    ev_valid = 0; en = 1; eval_done = 1;
    wait_idle();
    // async reset mid-WAIT with queued events
    eval_done = 0;
    send(1); send(2); send(3); send(4);
    repeat (3) step();
    #3 rst = 1; #1;
    chk("arst_busy", busy, 0);
    chk("arst_fill", fill, 0);
    chk("arst_win_shift", win_shift, 0);
    chk("arst_win_data", win_data, 0);
    chk("arst_eval_start", eval_start, 0);
    chk("arst_eval_kind", eval_kind, 0);
    chk("arst_tick_miss", tick_miss, 0);
    chk("arst_ready", ev_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // timer freezes while en is low: first periodic eval 3 cycles late
    eval_done = 1; en = 0;
    t = 0;
    while (!eval_start && t < 40) begin
      step(); t++;
      if (t == 3) en = 1;
    end
    chk("timer_first_eval_cycle", t, PERIOD + 4);
    chk("timer_first_eval_kind", eval_kind, 1);
    repeat (10) step();
    chk("arst_no_shift", shifts, 0);
    chk("arst_fill_after", fill, 0);
`ifdef SCHED_EVAL_TIMEOUT_EN
    wait_idle();
    eval_done = 0;
    send(77); send(78);
    t = 0;
    while (!eval_start && t < 40) begin step(); t++; end
    chk("to_eval_seen", eval_start, 1);
    repeat (TIMEOUT) step();
    chk("to_still_busy", busy, 1);
    chk("to_flag_early", eval_timeout, 0);
    step();
    chk("to_idle", busy, 0);
    chk("to_flag", eval_timeout, 1);
    eval_done = 1;
    wait_idle();
    chk("to_flag_sticky", eval_timeout, 1);
`else
    chk("no_timeout_flag", eval_timeout, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
